// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace record stream.
// Both the encoder and the trace readers import this package, so it is the
// single source of the record layout and type codes.
//   REC_W      : width of one packed trace record (109 bits)
//   *_LSB/_BIT : field offsets inside a record
//   trace_type_e : record type codes 1..4
package trace_pkg;

  localparam int REC_W     = 109;
  localparam int TYPE_LSB  = 106;  // [108:106] record type
  localparam int PC_LSB    = 74;   // [105:74]  PC of retiring instruction
  localparam int AUX_LSB   = 42;   // [73:42]   Address / next_pc / 0
  localparam int DATA_LSB  = 10;   // [41:10]   Write_data / RF_wdata / 0
  localparam int WADDR_LSB = 5;    // [9:5]     RF_waddr
  localparam int STRB_LSB  = 1;    // [4:1]     Write_strb
  localparam int MRD_BIT   = 0;    // [0]       MemRead

  typedef enum logic [2:0] {
    TT_NONE   = 3'd0,
    TT_ALU    = 3'd1,  // register write, no store
    TT_STORE  = 3'd2,  // memory write
    TT_BRANCH = 3'd3,  // no register write, no store (branches, fences, ...)
    TT_JUMP   = 3'd4   // jal/jalr with link register write
  } trace_type_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO for the commit trace encoder.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy register.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write request and record; refused only when full with no pop
//   pop         : read request; ignored when empty
//   rdata       : head record, forced to 0 while empty
//   valid       : FIFO non-empty
//   count       : current occupancy (0..DEPTH)
module trace_fifo #(
  parameter int WIDTH = 109,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, full, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);

  assign count = wr_ptr - rd_ptr;
  assign valid = ~empty;
  // Zero while empty so reset clears the visible record without resetting storage.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage holds data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_trace_encoder.sv
// Commit trace encoder: classifies each retiring instruction, packs it into a
// 109-bit trace record and buffers it in trace_fifo for a ready/valid consumer.
// Optional feature macro: TRACE_BACKPRESSURE_EN
//   defined   : cpu_stall asks the core to hold retirement near full; no drops counted
//   undefined : no cpu_stall port; overflowing commits are dropped and counted
// Ports:
//   clk, resetn              : clock, asynchronous active-low reset
//   commit_valid             : one instruction retires this cycle
//   PC, next_pc              : PC of retiring / following instruction
//   RF_wen/RF_waddr/RF_wdata : register-file write of the retiring instruction
//   MemWrite, MemRead        : memory strobes
//   Address/Write_strb/Write_data : store address, byte strobes, data
//   is_jump                  : retiring instruction is jal/jalr
//   trace_valid/ready/data   : record stream (head of FIFO)
//   drop_cnt                 : saturating count of dropped records
//   cpu_stall                : retirement hold request (backpressure build only)
module commit_trace_encoder
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             commit_valid,
  input  logic [31:0]      PC,
  input  logic [31:0]      next_pc,
  input  logic             RF_wen,
  input  logic [4:0]       RF_waddr,
  input  logic [31:0]      RF_wdata,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [31:0]      Address,
  input  logic [3:0]       Write_strb,
  input  logic [31:0]      Write_data,
  input  logic             is_jump,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [REC_W-1:0] trace_data,
  output logic [15:0]      drop_cnt
`ifdef TRACE_BACKPRESSURE_EN
  ,
  output logic             cpu_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  trace_type_e      ttype_p0;
  logic [REC_W-1:0] rec_p0;
  logic             pop;
  logic [AW:0]      count;

  always_comb begin
    ttype_p0 = TT_BRANCH;
    if (MemWrite)              ttype_p0 = TT_STORE;
    else if (is_jump && RF_wen) ttype_p0 = TT_JUMP;
    else if (RF_wen)           ttype_p0 = TT_ALU;
  end

  always_comb begin
    rec_p0 = '0;
    rec_p0[TYPE_LSB +: 3] = ttype_p0;
    rec_p0[PC_LSB +: 32]  = PC;
    case (ttype_p0)
      TT_STORE: begin
        rec_p0[AUX_LSB +: 32]  = Address;
        rec_p0[DATA_LSB +: 32] = Write_data;
        rec_p0[STRB_LSB +: 4]  = Write_strb;
      end
      TT_JUMP: begin
        rec_p0[AUX_LSB +: 32]  = next_pc;
        rec_p0[DATA_LSB +: 32] = RF_wdata;
        rec_p0[WADDR_LSB +: 5] = RF_waddr;
      end
      TT_ALU: begin
        rec_p0[DATA_LSB +: 32] = RF_wdata;
        rec_p0[WADDR_LSB +: 5] = RF_waddr;
        rec_p0[MRD_BIT]        = MemRead;
      end
      default: begin
        rec_p0[AUX_LSB +: 32]  = next_pc;
      end
    endcase
  end

  assign pop = trace_valid & trace_ready;

  // ---- stage boundary: record registered into the FIFO, visible next cycle ----
  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (commit_valid),
    .wdata  (rec_p0),
    .pop    (pop),
    .rdata  (trace_data),
    .valid  (trace_valid),
    .count  (count)
  );

`ifdef TRACE_BACKPRESSURE_EN
  localparam logic [AW:0] STALL_CNT = (AW+1)'(FIFO_DEPTH - 1);

  // Stall one entry early so the commit already in flight still fits.
  assign cpu_stall = (count >= STALL_CNT);
  assign drop_cnt  = '0;
`else
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic full_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full_p0 = (count == FULL_CNT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      drop_cnt <= '0;
    else if (commit_valid && full_p0 && !pop)
      drop_cnt <= sat_inc16(drop_cnt);
  end
`endif

endmodule

// File: tb/tb_commit_trace_encoder.sv
module tb_commit_trace_encoder;

  logic         clk = 1'b0;
  logic         resetn;
  logic         commit_valid;
  logic [31:0]  PC, next_pc;
  logic         RF_wen;
  logic [4:0]   RF_waddr;
  logic [31:0]  RF_wdata;
  logic         MemWrite, MemRead;
  logic [31:0]  Address;
  logic [3:0]   Write_strb;
  logic [31:0]  Write_data;
  logic         is_jump;
  logic         trace_valid, trace_ready;
  logic [108:0] trace_data;
  logic [15:0]  drop_cnt;
`ifdef TRACE_BACKPRESSURE_EN
  logic         cpu_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  commit_trace_encoder #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .commit_valid (commit_valid),
    .PC           (PC),
    .next_pc      (next_pc),
    .RF_wen       (RF_wen),
    .RF_waddr     (RF_waddr),
    .RF_wdata     (RF_wdata),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .Address      (Address),
    .Write_strb   (Write_strb),
    .Write_data   (Write_data),
    .is_jump      (is_jump),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_data   (trace_data),
    .drop_cnt     (drop_cnt)
`ifdef TRACE_BACKPRESSURE_EN
    ,
    .cpu_stall    (cpu_stall)
`endif
  );

  typedef struct {
    logic [31:0] pc, npc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mw, mr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic        jmp;
    logic [2:0]  et;
    logic [31:0] ea, ed;
    logic [4:0]  ewa;
    logic [3:0]  es;
    logic        emr;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [108:0] act, input logic [108:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [108:0] exp_rec(input vec_t v);
    return {v.et, v.pc, v.ea, v.ed, v.ewa, v.es, v.emr};
  endfunction

  task automatic drive(input vec_t v, input logic cv);
    commit_valid = cv;
    PC = v.pc; next_pc = v.npc; RF_wen = v.wen; RF_waddr = v.waddr; RF_wdata = v.wdata;
    MemWrite = v.mw; MemRead = v.mr; Address = v.addr; Write_strb = v.strb;
    Write_data = v.wd; is_jump = v.jmp;
  endtask

  // Simple register-writing commit whose PC identifies it in the stream.
  task automatic alu_commit(input logic [31:0] pc);
    commit_valid = 1'b1;
    PC = pc; next_pc = pc + 32'd4; RF_wen = 1'b1; RF_waddr = 5'd1; RF_wdata = pc;
    MemWrite = 1'b0; MemRead = 1'b0; Address = '0; Write_strb = '0; Write_data = '0;
    is_jump = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            pc        npc       wen   wa     wdata         mw    mr    addr      strb   wd         jmp   et    ea        ed            ewa    es     emr
    vt[0] = '{32'h10, 32'h14,  1'b1, 5'd5,  32'h1234,     1'b0, 1'b1, 32'h55,  4'hF, 32'h77,    1'b0, 3'd1, 32'h0,   32'h1234,     5'd5,  4'h0, 1'b1};
    vt[1] = '{32'h14, 32'h18,  1'b0, 5'd7,  32'h99,       1'b1, 1'b0, 32'h100, 4'h3, 32'hBEEF,  1'b0, 3'd2, 32'h100, 32'hBEEF,     5'd0,  4'h3, 1'b0};
    vt[2] = '{32'h20, 32'h80,  1'b1, 5'd31, 32'h24,       1'b0, 1'b1, 32'h0,   4'h0, 32'h0,     1'b1, 3'd4, 32'h80,  32'h24,       5'd31, 4'h0, 1'b0};
    vt[3] = '{32'h24, 32'h40,  1'b0, 5'd3,  32'h5,        1'b0, 1'b0, 32'h0,   4'h0, 32'h0,     1'b0, 3'd3, 32'h40,  32'h0,        5'd0,  4'h0, 1'b0};
    vt[4] = '{32'h28, 32'h2C,  1'b1, 5'd9,  32'hAAAA,     1'b1, 1'b0, 32'h200, 4'hC, 32'h5555,  1'b1, 3'd2, 32'h200, 32'h5555,     5'd0,  4'hC, 1'b0};
    vt[5] = '{32'h30, 32'h300, 1'b0, 5'd1,  32'h11,       1'b0, 1'b1, 32'h0,   4'h0, 32'h0,     1'b1, 3'd3, 32'h300, 32'h0,        5'd0,  4'h0, 1'b0};
    vt[6] = '{32'h34, 32'h38,  1'b1, 5'd12, 32'hDEADBEEF, 1'b0, 1'b0, 32'h4,   4'h1, 32'h2,     1'b0, 3'd1, 32'h0,   32'hDEADBEEF, 5'd12, 4'h0, 1'b0};

    resetn = 1'b0;
    trace_ready = 1'b0;
    drive(vt[0], 1'b0);

    // Reset state
    #12;
    chk("reset_valid", trace_valid, 0);
    chk("reset_data", trace_data, 0);
    chk("reset_drop", drop_cnt, 0);
`ifdef TRACE_BACKPRESSURE_EN
    chk("reset_stall", cpu_stall, 0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Inputs are ignored without commit_valid
    trace_ready = 1'b1;
    drive(vt[1], 1'b0);
    step();
    step();
    chk("idle_no_valid", trace_valid, 0);

    // Table-driven classification/packing, ready held high
    for (int i = 0; i < 7; i++) begin
      drive(vt[i], 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_latency", i), trace_valid, 0);
      step();
      commit_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), trace_valid, 1);
      chk($sformatf("vec%0d_data", i), trace_data, exp_rec(vt[i]));
      step();
      chk($sformatf("vec%0d_popped", i), trace_valid, 0);
    end

    // Fill to full with consumer stalled; head must hold
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alu_commit(32'h1000 + 32'(4 * i));
      step();
      chk($sformatf("fill%0d_head", i), trace_data[105:74], 32'h1000);
`ifdef TRACE_BACKPRESSURE_EN
      chk($sformatf("fill%0d_stall", i), cpu_stall, (i >= 6) ? 1 : 0);
`endif
    end
    // Ninth commit finds the FIFO full
    alu_commit(32'h1020);
    step();
    commit_valid = 1'b0;
`ifdef TRACE_BACKPRESSURE_EN
    chk("overflow_drop", drop_cnt, 0);
`else
    chk("overflow_drop", drop_cnt, 1);
`endif
    chk("overflow_head", trace_data[105:74], 32'h1000);

    // Full plus pop and push in the same cycle
    alu_commit(32'h2000);
    trace_ready = 1'b1;
    step();
    commit_valid = 1'b0;
    trace_ready = 1'b0;
`ifdef TRACE_BACKPRESSURE_EN
    chk("fullpop_drop", drop_cnt, 0);
    chk("fullpop_stall", cpu_stall, 1);
`else
    chk("fullpop_drop", drop_cnt, 1);
`endif
    chk("fullpop_head", trace_data[105:74], 32'h1004);
    trace_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("drain%0d_pc", i), trace_data[105:74], 32'h1000 + 32'(4 * i));
      step();
    end
    chk("drain_last_pc", trace_data[105:74], 32'h2000);
    chk("drain_last_type", trace_data[108:106], 3'd1);
    step();
    chk("drain_empty", trace_valid, 0);

    // Reset while records are buffered
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_commit(32'h3000 + 32'(4 * i));
      step();
    end
    commit_valid = 1'b0;
    chk("prereset_valid", trace_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", trace_valid, 0);
    chk("async_reset_data", trace_data, 0);
    chk("async_reset_drop", drop_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    trace_ready = 1'b1;
    step();
    chk("postreset_no_stale", trace_valid, 0);
    drive(vt[2], 1'b1);
    step();
    commit_valid = 1'b0;
    chk("postreset_valid", trace_valid, 1);
    chk("postreset_data", trace_data, exp_rec(vt[2]));
    step();
    chk("postreset_empty", trace_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
